// File: rtl/lsu_ram_if.sv
// Load/store initiator for the shared RAM data ports: word-aligns requests, splits accesses that
// cross a word boundary into two RAM cycles and returns extended load data over valid/ready.
module lsu_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_lsu_req_valid,
  output logic                    o_lsu_req_ready,
  input  logic                    i_lsu_req_wr,
  input  logic [1:0]              i_lsu_req_size,
  input  logic                    i_lsu_req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_req_data,
  output logic                    o_lsu_resp_valid,
  input  logic                    i_lsu_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_lsu_resp_data,
  output logic                    o_ram_rd_data_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_rd_data_addr,
  input  logic [DATA_WIDTH-1:0]   i_ram_rd_data_data,
  output logic                    o_ram_wr_data_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_wr_data_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_wr_data_data,
  output logic [DATA_WIDTH/8-1:0] o_ram_wr_data_mask
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(BYTES);
  // Wide enough to hold n and o + n without overflow.
  localparam int unsigned NW    = OFF + 2;

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic                    r_wr;
  logic                    r_unsigned;
  logic [1:0]              r_size;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_buf0;
  logic [DATA_WIDTH-1:0]   r_buf1;

  logic [1:0]              w_size_eff;
  logic [OFF-1:0]          w_off;
  logic [NW-1:0]           w_n;
  logic                    w_split;
  logic [ADDR_WIDTH-1:0]   w_base;
  logic [2*BYTES-1:0]      w_lane_mask;
  logic [2*BYTES-1:0]      w_mask_wide;
  logic [2*DATA_WIDTH-1:0] w_data_wide;
  logic [DATA_WIDTH-1:0]   w_rd_shift;
  logic                    w_sign;
  logic [DATA_WIDTH-1:0]   w_load_data;

  // Request decode; the second-word halves of the wide vectors feed the ACC1 cycle.
  always_comb begin
    w_size_eff  = (r_size > 2'(OFF)) ? 2'(OFF) : r_size;
    w_off       = r_addr[OFF-1:0];
    w_n         = NW'(1) << w_size_eff;
    w_split     = (NW'(w_off) + w_n) > NW'(BYTES);
    w_base      = {r_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    w_lane_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_lane_mask[i] = (NW'(i) < w_n);
    end
    w_mask_wide = w_lane_mask << w_off;
    w_data_wide = {{DATA_WIDTH{1'b0}}, r_data} << {w_off, 3'b000};
    w_rd_shift  = DATA_WIDTH'({r_buf1, r_buf0} >> {w_off, 3'b000});
    w_sign      = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (NW'(i + 1) == w_n) w_sign = w_rd_shift[8*i+7];
    end
    w_load_data = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_load_data[8*i +: 8] = (NW'(i) < w_n) ? w_rd_shift[8*i +: 8]
                                             : {8{w_sign & ~r_unsigned}};
    end
  end

  always_comb begin
    w_state_next       = r_state;
    o_lsu_req_ready    = 1'b0;
    o_lsu_resp_valid   = 1'b0;
    o_lsu_resp_data    = '0;
    o_ram_rd_data_en   = 1'b0;
    o_ram_rd_data_addr = '0;
    o_ram_wr_data_en   = 1'b0;
    o_ram_wr_data_addr = '0;
    o_ram_wr_data_data = '0;
    o_ram_wr_data_mask = '0;
    unique case (r_state)
      StIdle: begin
        o_lsu_req_ready = 1'b1;
        if (i_lsu_req_valid) w_state_next = StAcc0;
      end
      StAcc0: begin
        if (r_wr) begin
          o_ram_wr_data_en   = 1'b1;
          o_ram_wr_data_addr = w_base;
          o_ram_wr_data_mask = w_mask_wide[BYTES-1:0];
          o_ram_wr_data_data = w_data_wide[DATA_WIDTH-1:0];
        end else begin
          o_ram_rd_data_en   = 1'b1;
          o_ram_rd_data_addr = w_base;
        end
        w_state_next = w_split ? StAcc1 : StResp;
      end
      StAcc1: begin
        if (r_wr) begin
          o_ram_wr_data_en   = 1'b1;
          o_ram_wr_data_addr = w_base + ADDR_WIDTH'(BYTES);
          o_ram_wr_data_mask = w_mask_wide[2*BYTES-1:BYTES];
          o_ram_wr_data_data = w_data_wide[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
          o_ram_rd_data_en   = 1'b1;
          o_ram_rd_data_addr = w_base + ADDR_WIDTH'(BYTES);
        end
        w_state_next = StResp;
      end
      StResp: begin
        o_lsu_resp_valid = 1'b1;
        o_lsu_resp_data  = r_wr ? '0 : w_load_data;
        if (i_lsu_resp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state    <= StIdle;
      r_wr       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && i_lsu_req_valid) begin
        r_wr       <= i_lsu_req_wr;
        r_size     <= i_lsu_req_size;
        r_unsigned <= i_lsu_req_unsigned;
        r_addr     <= i_lsu_req_addr;
        r_data     <= i_lsu_req_data;
        r_buf0     <= '0;
        // Stays zero for unsplit loads so the upper word never leaks into the result.
        r_buf1     <= '0;
      end
      if (r_state == StAcc0 && !r_wr) r_buf0 <= i_ram_rd_data_data;
      if (r_state == StAcc1 && !r_wr) r_buf1 <= i_ram_rd_data_data;
    end
  end

endmodule

// File: tb/tb_lsu_ram_if.sv
// Randomized scoreboard bench for lsu_ram_if: a byte-level reference memory predicts RAM accesses
// and responses, and negedge monitors compare them against the DUT.
module tb_lsu_ram_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_lsu_req_valid = 1'b0;
  logic        o_lsu_req_ready;
  logic        i_lsu_req_wr = 1'b0;
  logic [1:0]  i_lsu_req_size = '0;
  logic        i_lsu_req_unsigned = 1'b0;
  logic [31:0] i_lsu_req_addr = '0;
  logic [31:0] i_lsu_req_data = '0;
  logic        o_lsu_resp_valid;
  logic        i_lsu_resp_ready;
  logic [31:0] o_lsu_resp_data;
  logic        o_ram_rd_data_en;
  logic [31:0] o_ram_rd_data_addr;
  logic [31:0] i_ram_rd_data_data;
  logic        o_ram_wr_data_en;
  logic [31:0] o_ram_wr_data_addr;
  logic [31:0] o_ram_wr_data_data;
  logic [3:0]  o_ram_wr_data_mask;

  lsu_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_sys_clk          (clk),
    .i_sys_rst          (rst),
    .i_lsu_req_valid    (i_lsu_req_valid),
    .o_lsu_req_ready    (o_lsu_req_ready),
    .i_lsu_req_wr       (i_lsu_req_wr),
    .i_lsu_req_size     (i_lsu_req_size),
    .i_lsu_req_unsigned (i_lsu_req_unsigned),
    .i_lsu_req_addr     (i_lsu_req_addr),
    .i_lsu_req_data     (i_lsu_req_data),
    .o_lsu_resp_valid   (o_lsu_resp_valid),
    .i_lsu_resp_ready   (i_lsu_resp_ready),
    .o_lsu_resp_data    (o_lsu_resp_data),
    .o_ram_rd_data_en   (o_ram_rd_data_en),
    .o_ram_rd_data_addr (o_ram_rd_data_addr),
    .i_ram_rd_data_data (i_ram_rd_data_data),
    .o_ram_wr_data_en   (o_ram_wr_data_en),
    .o_ram_wr_data_addr (o_ram_wr_data_addr),
    .o_ram_wr_data_data (o_ram_wr_data_data),
    .o_ram_wr_data_mask (o_ram_wr_data_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int unsigned acc;
    int unsigned lat;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    int unsigned cyc;
  } acc_t;

  resp_t       rq[$];
  acc_t        aq[$];
  logic [7:0]  ram [1024] = '{default: 8'h00};
  logic [7:0]  refm [1024];
  int          checks = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned last_hs = 0;
  bit          resp_seen = 0;
  int          rr_mode = 2;   // 0 random, 1 held low, 2 held high
  logic        rr_rand = 1'b1;

  assign i_lsu_resp_ready = (rr_mode == 1) ? 1'b0 : (rr_mode == 2) ? 1'b1 : rr_rand;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rr_rand <= ($urandom_range(0, 3) != 0);

  // RAM model: 1 KiB byte array, address bits above 9 ignored.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      i_ram_rd_data_data[8*i +: 8] = ram[o_ram_rd_data_addr[9:0] + 10'(i)];
    end
  end

  always @(posedge clk) begin
    if (o_ram_wr_data_en) begin
      for (int i = 0; i < 4; i++) begin
        if (o_ram_wr_data_mask[i]) ram[o_ram_wr_data_addr[9:0] + 10'(i)] <= o_ram_wr_data_data[8*i +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-granular memory plus the access/response sequence it implies.
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] data, input bit abort, input int unsigned acc);
    int          n;
    int          o;
    bit          split;
    logic [63:0] val;
    acc_t        w0;
    acc_t        w1;
    n = 1 << ((sz > 2) ? 2 : int'(sz));
    o = int'(addr[1:0]);
    split = 0;
    val = '0;
    w0.wr = wr; w0.addr = addr & 32'hFFFF_FFFC;        w0.mask = '0; w0.data = '0; w0.cyc = acc + 1;
    w1.wr = wr; w1.addr = (addr & 32'hFFFF_FFFC) + 4;  w1.mask = '0; w1.data = '0; w1.cyc = acc + 2;
    for (int i = 0; i < n; i++) begin
      int         lane;
      logic [9:0] ix;
      lane = o + i;
      ix = addr[9:0] + 10'(i);
      if (lane < 4) begin
        w0.mask[lane] = 1'b1;
        w0.data[8*lane +: 8] = data[8*i +: 8];
      end else begin
        split = 1;
        w1.mask[lane-4] = 1'b1;
        w1.data[8*(lane-4) +: 8] = data[8*i +: 8];
      end
      if (wr && !(abort && lane >= 4)) refm[ix] = data[8*i +: 8];
      val[8*i +: 8] = refm[ix];
    end
    if (!uns && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
    aq.push_back(w0);
    if (split && !abort) aq.push_back(w1);
    if (!abort) rq.push_back('{data: (wr ? 32'd0 : val[31:0]), acc: acc, lat: (split ? 3 : 2)});
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] data, input bit abort, output int unsigned acc);
    int t;
    i_lsu_req_wr = wr;
    i_lsu_req_size = sz;
    i_lsu_req_unsigned = uns;
    i_lsu_req_addr = addr;
    i_lsu_req_data = data;
    i_lsu_req_valid = 1'b1;
    acc = 0;
    t = 0;
    @(negedge clk);
    while (!o_lsu_req_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!o_lsu_req_ready) begin
      checks++;
      fails++;
      $display("FAIL req_accept_timeout waited=%0d required<100", t);
      i_lsu_req_valid = 1'b0;
      return;
    end
    acc = cyc;
    model(wr, sz, uns, addr, data, abort, acc);
    @(posedge clk);
    #1 i_lsu_req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || aq.size() != 0 || !o_lsu_req_ready) && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("drain_pending", 64'(rq.size() + aq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: RAM accesses and responses, compared against the queued predictions.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rd_wr_exclusive", 64'(o_ram_rd_data_en & o_ram_wr_data_en), 64'd0);
        if (o_ram_rd_data_en || o_ram_wr_data_en) begin
          if (aq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_ram_access rd=%0b wr=%0b addr=%0h required=none",
                     o_ram_rd_data_en, o_ram_wr_data_en,
                     o_ram_wr_data_en ? o_ram_wr_data_addr : o_ram_rd_data_addr);
          end else begin
            acc_t a;
            a = aq.pop_front();
            chk("access_cycle", 64'(cyc), 64'(a.cyc));
            chk("access_is_write", 64'(o_ram_wr_data_en), 64'(a.wr));
            if (a.wr) begin
              logic [31:0] m;
              for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{a.mask[i]}};
              chk("wr_addr", 64'(o_ram_wr_data_addr), 64'(a.addr));
              chk("wr_mask", 64'(o_ram_wr_data_mask), 64'(a.mask));
              chk("wr_data", 64'(o_ram_wr_data_data & m), 64'(a.data & m));
            end else begin
              chk("rd_addr", 64'(o_ram_rd_data_addr), 64'(a.addr));
            end
          end
        end
        if (o_lsu_resp_valid) begin
          chk("req_ready_while_resp", 64'(o_lsu_req_ready), 64'd0);
          if (rq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp data=%0h required=none", o_lsu_resp_data);
          end else begin
            chk("resp_data", 64'(o_lsu_resp_data), 64'(rq[0].data));
            if (!resp_seen) chk("resp_latency", 64'(cyc - rq[0].acc), 64'(rq[0].lat));
            resp_seen = 1;
            if (i_lsu_resp_ready) begin
              void'(rq.pop_front());
              resp_seen = 0;
              last_hs = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    int unsigned acc;
    int unsigned acc2;
    int          t;
    int          bad;
    for (int i = 0; i < 1024; i++) refm[i] = 8'h00;
    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", 64'(o_lsu_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(o_lsu_resp_valid), 64'd0);
    chk("rst_rd_en", 64'(o_ram_rd_data_en), 64'd0);
    chk("rst_wr_en", 64'(o_ram_wr_data_en), 64'd0);
    chk("rst_resp_data", 64'(o_lsu_resp_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_req_ready", 64'(o_lsu_req_ready), 64'd1);
      chk("idle_quiet", 64'({o_lsu_resp_valid, o_ram_rd_data_en, o_ram_wr_data_en}), 64'd0);
    end
    @(posedge clk);
    #1;

    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, acc);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, acc);
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, acc);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, acc);
    issue(1'b1, 2'd1, 1'b0, 32'h107, 32'h0000_A55A, 0, acc);
    issue(1'b0, 2'd1, 1'b0, 32'h107, 32'h0, 0, acc);
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, acc);
    issue(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'h0, 0, acc);
    issue(1'b0, 2'd3, 1'b0, 32'h101, 32'h0, 0, acc);
    issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h1234_5678, 0, acc);
    drain();

    // Backpressure: response held for three cycles while a new request waits.
    rr_mode = 1;
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, acc);
    fork
      begin
        t = 0;
        while (!o_lsu_resp_valid && t < 20) begin
          t++;
          @(negedge clk);
        end
        repeat (3) begin
          chk("bp_resp_valid_held", 64'(o_lsu_resp_valid), 64'd1);
          chk("bp_req_ready_low", 64'(o_lsu_req_ready), 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 rr_mode = 2;
      end
      issue(1'b1, 2'd0, 1'b0, 32'h300, 32'h0000_0077, 0, acc2);
    join
    chk("bp_accept_after_handshake", 64'(acc2), 64'(last_hs + 1));
    drain();

    // Reset during ACC1 of a split store: only the first word may land.
    issue(1'b1, 2'd2, 1'b0, 32'h1FE, 32'h89AB_CDEF, 1, acc);
    @(posedge clk);
    #1;
    chk("split_acc1_wr_en", 64'(o_ram_wr_data_en), 64'd1);
    chk("split_acc1_addr", 64'(o_ram_wr_data_addr), 64'h200);
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", 64'(o_ram_wr_data_en), 64'd0);
    chk("async_rst_req_ready", 64'(o_lsu_req_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_req_ready", 64'(o_lsu_req_ready), 64'd1);
    end
    chk("post_rst_pending", 64'(rq.size() + aq.size()), 64'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 1'b1, 32'h1FE, 32'h0, 0, acc);

    rr_mode = 0;
    repeat (300) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'h100 + 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
            32'($urandom), 0, acc);
    end
    drain();

    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== refm[i]) bad++;
    chk("ram_contents_bytes_differing", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ram_if.md
Name: lsu_ram_if

Overview:
- Load/store initiator that drives the data read and data write ports of the shared instruction/data RAM on behalf of the execute stage.
- Accepts one load/store request at a time over a valid/ready handshake.
- Generates word-aligned RAM addresses, per-byte write masks and lane-shifted write data.
- Splits accesses that cross a word boundary into two RAM accesses, then returns sign-/zero-extended load data over a valid/ready response channel.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): RAM word width. Legal values are 32 and 64. BYTES = DATA_WIDTH/8, OFF = log2(BYTES).
- ADDR_WIDTH, `ADDR_WIDTH (32): request and RAM address width.

Ports:
- i_sys_clk  in  1  clock.
- i_sys_rst  in  1  reset; asynchronous, active-high.
- i_lsu_req_valid  in  1  request valid.
- o_lsu_req_ready  out  1  request accepted when valid&ready.
- i_lsu_req_wr  in  1  1 = store, 0 = load.
- i_lsu_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword. Sizes above OFF are treated as full width.
- i_lsu_req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- i_lsu_req_addr  in  ADDR_WIDTH  byte address.
- i_lsu_req_data  in  DATA_WIDTH  store data, right-aligned.
- o_lsu_resp_valid  out  1  response valid; issued for loads and stores.
- i_lsu_resp_ready  in  1  response consumed.
- o_lsu_resp_data  out  DATA_WIDTH  extended load data; 0 for stores.
- o_ram_rd_data_en  out  1  RAM data read enable.
- o_ram_rd_data_addr  out  ADDR_WIDTH  word-aligned read address (low OFF bits = 0).
- i_ram_rd_data_data  in  DATA_WIDTH  combinational read data from RAM.
- o_ram_wr_data_en  out  1  RAM write enable.
- o_ram_wr_data_addr  out  ADDR_WIDTH  word-aligned write address.
- o_ram_wr_data_data  out  DATA_WIDTH  lane-shifted write data.
- o_ram_wr_data_mask  out  BYTES  byte-lane write mask.

Behaviour:
- Reset is asynchronous and active-high. While i_sys_rst is high:
  - state = IDLE;
  - all outputs 0 except o_lsu_req_ready = 1;
  - request and read-buffer registers cleared.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - o_lsu_req_ready = 1.
  - On valid&ready, latch wr, size, unsigned, addr and data, then go to ACC0.
- Request decode:
  - o = addr[OFF-1:0]; n = min(1<<size, BYTES); split = (o + n > BYTES).
  - Base word address A = addr with low OFF bits cleared.
- ACC0:
  - Drive address A for one cycle.
  - Store: wr_en = 1, mask = (((1<<n)-1) << o) truncated to BYTES bits, data = req_data << 8*o.
  - Load: rd_en = 1; capture i_ram_rd_data_data into buf0 at the clock edge.
  - Next state: ACC1 if split, else RESP.
- ACC1:
  - Drive address A + BYTES for one cycle; the address wraps modulo 2^ADDR_WIDTH.
  - Store: mask = ((1<<n)-1) >> (BYTES-o), data = req_data >> 8*(BYTES-o).
  - Load: capture buf1.
  - Next state: RESP.
- RESP:
  - o_lsu_resp_valid = 1.
  - Load data = ({buf1,buf0} >> 8*o), truncated to n bytes, then zero- or sign-extended from bit 8n-1. buf1 is 0 when the access is not split.
  - o_lsu_resp_data holds stable while valid && !ready.
  - Leave to IDLE on i_lsu_resp_ready.
- Read and write enables are never both high. Both are 0 outside ACC0/ACC1.
- Latency, with the request accepted at edge N:
  - ACC0 occupies cycle N+1.
  - Response valid at N+2 (aligned) or N+3 (split).
  - Next request can be accepted one cycle after the response handshake.
- Requests are not accepted in ACC0, ACC1 or RESP (ready = 0).
- Reset mid-operation: abort immediately and return to IDLE. A store half already written in ACC0 is not rolled back.
- Size 3 with DATA_WIDTH = 32 behaves as size 2.

Test Plan:
- Reset, then idle: req_ready = 1; resp_valid, rd_en and wr_en = 0 on every cycle.
- Store word 0xDEADBEEF @0x100, then load word @0x100.
  - Store: ACC0 drives wr_en = 1, addr 0x100, mask 4'b1111, data 0xDEADBEEF.
  - Load: resp 0xDEADBEEF two cycles after acceptance.
- Load byte @0x103 from that word:
  - signed → 0xFFFFFFDE;
  - unsigned → 0x000000DE;
  - one RAM read only; rd_addr = 0x100.
- Misaligned store half 0xA55A @0x107:
  - ACC0: addr 0x104, mask 4'b1000, data[31:24] = 0x5A.
  - ACC1: addr 0x108, mask 4'b0001, data[7:0] = 0xA5.
  - Signed half load @0x107 → 0xFFFFA55A, response valid at N+3.
- Backpressure: hold resp_ready = 0 for 3 cycles on a load of 0x12345678.
  - resp_valid stays 1 and data stays 0x12345678.
  - req_ready stays 0 while a new request valid is held.
  - The held request is accepted in the cycle after the handshake.
- Reset asserted during ACC1 of a split store:
  - wr_en drops to 0 asynchronously.
  - After release: state IDLE, req_ready = 1, no ACC1 write observed.
